// File: rtl/nco_sin16.sv
// nco_sin16 -- numerically controlled oscillator, signed 16-bit sine output.
//
// A PHASE_W-bit phase accumulator advances by a tuning word each enabled
// cycle. The top LUT_AW+2 phase bits address a quarter-wave sine table built
// at elaboration; the quadrant selects mirroring and sign. Output is
// registered through a 2-stage pipeline (lookup, then sign apply).
// f_out = FTW * f_clk / 2^PHASE_W.
//
// Optional feature: define NCO_COS_EN to add a cos16 output, a quadrature
// sample taken from the same table and aligned with sin16.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   en         in   advance phase and emit a sample this cycle
//   ftw_in     in   PHASE_W-bit unsigned tuning word
//   ftw_load   in   single-cycle strobe, capture ftw_in
//   phase_clr  in   synchronous phase reset to 0
//   sin16      out  signed sample, two's complement
//   cos16      out  signed quadrature sample (NCO_COS_EN only)
//   out_valid  out  sin16 holds a new sample this cycle

module nco_sin16 #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int AMPL    = 32000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_load,
    input  logic               phase_clr,
    output logic [15:0]        sin16,
`ifdef NCO_COS_EN
    output logic [15:0]        cos16,
`endif
    output logic               out_valid
);

    localparam int                LUT_N    = 1 << LUT_AW;
    localparam real               PI       = 3.14159265358979323846;
    localparam logic [LUT_AW:0]   IDX_FULL = (LUT_AW+1)'(LUT_N);

    // Quarter-wave table, entries 0..2^LUT_AW inclusive (all non-negative).
    logic [15:0] w_lut [0:LUT_N];

    for (genvar k = 0; k <= LUT_N; k++) begin : g_lut
        localparam int V = $rtoi(real'(AMPL) *
                                 $sin(PI / 2.0 * real'(k) / real'(LUT_N)) + 0.5);
        assign w_lut[k] = 16'(V);
    end

    logic [PHASE_W-1:0] r_ftw;
    logic [PHASE_W-1:0] r_phase;

    logic [1:0]         w_sin_q;
    logic [LUT_AW-1:0]  w_idx_raw;
    logic [LUT_AW:0]    w_sin_idx;
    logic [15:0]        w_sin_mag;

    logic [15:0]        r_sin_mag;
    logic               r_sin_neg;
    logic               r_va;
    logic [15:0]        r_sin16;
    logic               r_valid;

    assign w_sin_q   = r_phase[PHASE_W-1 -: 2];
    assign w_idx_raw = r_phase[PHASE_W-3 -: LUT_AW];

    // Odd quadrants read the table mirrored: index 2^LUT_AW - i.
    assign w_sin_idx = w_sin_q[0] ? (IDX_FULL - {1'b0, w_idx_raw}) : {1'b0, w_idx_raw};
    assign w_sin_mag = w_lut[w_sin_idx];

`ifdef NCO_COS_EN
    logic [1:0]         w_cos_q;
    logic [LUT_AW:0]    w_cos_idx;
    logic [15:0]        w_cos_mag;
    logic [15:0]        r_cos_mag;
    logic               r_cos_neg;
    logic [15:0]        r_cos16;

    // Adding 2^(PHASE_W-2) to the phase only bumps the quadrant; the table
    // index bits are unchanged, so no full-width adder is needed.
    assign w_cos_q   = w_sin_q + 2'd1;
    assign w_cos_idx = w_cos_q[0] ? (IDX_FULL - {1'b0, w_idx_raw}) : {1'b0, w_idx_raw};
    assign w_cos_mag = w_lut[w_cos_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cos_mag <= '0;
            r_cos_neg <= 1'b0;
            r_cos16   <= '0;
        end else begin
            r_cos_mag <= w_cos_mag;
            r_cos_neg <= w_cos_q[1];
            if (r_va) begin
                r_cos16 <= r_cos_neg ? -r_cos_mag : r_cos_mag;
            end
        end
    end

    assign cos16 = r_cos16;
`endif

    // Phase accumulator and tuning word; a loaded word is first used next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ftw   <= '0;
            r_phase <= '0;
        end else begin
            if (ftw_load) begin
                r_ftw <= ftw_in;
            end
            if (phase_clr) begin
                r_phase <= '0;
            end else if (en) begin
                r_phase <= r_phase + r_ftw;
            end
        end
    end

    // Stage A: table lookup; stage B: sign apply, hold when no sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sin_mag <= '0;
            r_sin_neg <= 1'b0;
            r_va      <= 1'b0;
            r_sin16   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_sin_mag <= w_sin_mag;
            r_sin_neg <= w_sin_q[1];
            r_va      <= en;
            r_valid   <= r_va;
            if (r_va) begin
                r_sin16 <= r_sin_neg ? -r_sin_mag : r_sin_mag;
            end
        end
    end

    assign sin16     = r_sin16;
    assign out_valid = r_valid;

endmodule

// File: doc/nco_sin16.md
Name: nco_sin16

Overview:
- Numerically controlled oscillator that produces a signed 16-bit sine sample stream for the FIR filter instances.
- Sits directly upstream of the fir stage.
- Replaces the behavioural real-math sine generator with synthesizable RTL: a 32-bit phase accumulator, a quarter-wave lookup table, and a 2-stage output pipeline.
- Frequency is set by a tuning word (FTW): f_out = FTW * f_clk / 2^PHASE_W.

Parameters:
- PHASE_W, 32: phase accumulator and FTW width.
- LUT_AW, 8: quarter-wave index bits. The table has 2^LUT_AW+1 entries.
- AMPL, 32000: peak output amplitude. Must be ≤ 32767.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  advance the phase and emit a sample this cycle.
- ftw_in  in  PHASE_W  tuning word, unsigned.
- ftw_load  in  1  single-cycle strobe: capture ftw_in.
- phase_clr  in  1  synchronous phase reset to 0.
- sin16  out  16  signed sample, two's complement.
- out_valid  out  1  sin16 holds a new sample this cycle.

Behaviour:
- Reset is asynchronous and active-high.
  - rst=1 forces ftw_reg=0, phase_acc=0, all pipeline registers=0, sin16=0, out_valid=0.
  - Release is synchronous to clk. The first update happens on the first rising edge with rst=0.
- LUT:
  - LUT[k] = round(AMPL*sin(pi/2 * k/2^LUT_AW)) for k = 0..2^LUT_AW.
  - Built at elaboration with a constant/initial function. Icarus-compatible $sin is allowed.
  - LUT[0]=0. LUT[2^LUT_AW]=AMPL.
- Phase decode uses the top LUT_AW+2 bits of the phase:
  - q = phase[PHASE_W-1:PHASE_W-2]; i = next LUT_AW bits.
  - q0: +LUT[i]
  - q1: +LUT[2^LUT_AW - i]
  - q2: -LUT[i]
  - q3: -LUT[2^LUT_AW - i]
  - Lower phase bits are truncated, with no interpolation.
- Per rising edge k:
  - Stage A registers mag = LUT lookup of the current phase_acc, neg = q[1], and va = en.
  - phase_acc update priority: phase_clr → 0; else en → phase_acc + ftw_reg (mod 2^PHASE_W, wrap-around silent); else hold.
  - ftw_load=1 → ftw_reg <= ftw_in. The new word is first used on the following edge.
  - Simultaneous phase_clr and ftw_load: both take effect.
- Edge k+1 (stage B):
  - If va=1: sin16 <= neg ? -mag : mag, and out_valid <= 1.
  - If va=0: sin16 holds and out_valid <= 0.
- Latency:
  - The phase_acc value present before edge k appears on sin16 after edge k+1, i.e. 2 edges.
  - Throughput is 1 sample/clk while en=1.
- en=0 mid-stream:
  - Phase frozen. The pipeline drains and produces no further valid samples.
  - Resume continues from the frozen phase with no skipped or duplicated sample.
- Negation never overflows because AMPL ≤ 32767.
- FTW ≥ 2^(PHASE_W-1) gives aliased output. This is legal and not flagged.
- ftw_reg=0 with en=1 gives a constant sample stream at the current phase.
- Reset mid-stream clears everything immediately, with no clock needed.

Optional Feature:
- Macro: NCO_COS_EN.
- Defined:
  - Adds output port cos16 (out, 16, signed).
  - cos16 is computed from phase_acc + 2^(PHASE_W-2) through a second LUT read of the same table and the same 2-stage pipeline.
  - It is aligned with sin16 and out_valid. Reset value 0; holds when va=0.
- Undefined:
  - Port absent, no extra logic.
  - sin16 behaviour is identical in both builds.

Test Plan:
- Reset, then ftw_load with ftw_in=32'h40000000, en=1 from the next cycle → the out_valid samples repeat 0, 32000, 0, -32000.
- ftw_in=32'h20000000, en=1 → samples 0, 22627, 32000, 22627, 0, -22627, -32000, -22627, repeating (LUT[128] = round(32000*sin(pi/4))).
- ftw_in=32'h40000000 running; drop en for 3 cycles then raise it → out_valid low for exactly 3 cycles, two edges after en falls; the sequence resumes with no gap or repeat.
- Assert phase_clr together with ftw_load (new FTW 32'h80000000) mid-stream → the next valid sample is 0, then alternating 0, 0 (q2 index 0 = -0). No glitch values.
- Assert rst asynchronously between edges while streaming → sin16=0 and out_valid=0 immediately. After release and ftw reload, the first sample is 0.
- With NCO_COS_EN defined and ftw_in=32'h40000000 → cos16 sequence 32000, 0, -32000, 0, aligned with sin16. Self-check sin16²+cos16² within ±2% of 32000² for ftw_in=32'h01000000 over 256 samples.
